// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO for buffering values between
// softmax pipeline stages. Supports any depth from 2 to 4096, occupancy count,
// full/empty/almost flags, overflow/underflow pulses, and either a registered
// (standard) read port or a first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in_fifo,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out_fifo,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    // Thresholds and wrap point sized to the count/pointer widths so the
    // compares below are all same-width.
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // A read needs data; a write needs room, or a slot freed by a same-cycle read.
    always_comb begin
        rd_acc = rd_en & ~empty;
        wr_acc = wr_en & (~full | rd_acc);
    end

    // Flags are pure decodes of the count register.
    always_comb begin
        full         = (count == DEPTH_CNT);
        empty        = (count == '0);
        almost_full  = (count >= AF_CNT);
        almost_empty = (count <= AE_CNT);
    end

    // Storage: written only on an accepted write, never cleared by clr.
    always_ff @(posedge clk) begin
        if (!clr && wr_acc) begin
            mem[wr_ptr] <= data_in_fifo;
        end
    end

    // Pointers advance on acceptance and wrap at DEPTH-1, so any depth works.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous accepted read and write cancel out.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered one-cycle error pulses for rejected requests.
    always_ff @(posedge clk) begin
        if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] data_q;
            logic                  valid_q;

            // Standard read: one-cycle latency, data holds when no read is accepted.
            always_ff @(posedge clk) begin
                if (clr) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        data_q <= mem[rd_ptr];
                    end
                end
            end

            assign data_out_fifo = data_q;
            assign valid_out     = valid_q;
        end else begin : g_fwft
            // Fall-through read: head word is always presented, rd_en pops it.
            assign data_out_fifo = mem[rd_ptr];
            assign valid_out     = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives three FIFO instances (standard depth 8, standard
// depth 6, fall-through depth 8) with a shared directed-then-random stream and
// checks them against a circular-buffer reference model through a scoreboard.
module tb_sync_fifo_param;

    typedef struct packed {
        logic [3:0]  cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic        ovf;
        logic        udf;
        logic        vld;
        logic        dchk;
        logic [15:0] data;
    } dexp_t;
    typedef dexp_t [2:0] cyc_t;

    logic        clk;
    logic        clr;
    logic        wrEn;
    logic        rdEn;
    logic [15:0] dataIn;

    logic [15:0] dout   [3];
    logic        vldO   [3];
    logic        fullO  [3];
    logic        emptyO [3];
    logic        afO    [3];
    logic        aeO    [3];
    logic [3:0]  cntO   [3];
    logic        ovfO   [3];
    logic        udfO   [3];

    int checks = 0;
    int errors = 0;

    // Reference model: plain circular buffer per instance.
    int          dep [3] = '{8, 6, 8};
    int          afl [3] = '{6, 4, 6};
    int          ael [3] = '{2, 1, 2};
    bit          fw  [3] = '{0, 0, 1};
    logic [15:0] mmem [3][8];
    int          mhead [3];
    int          mcnt  [3];
    logic [15:0] mlast [3];

    cyc_t        expq [$];
    logic [15:0] rdq0 [$];
    logic [15:0] rdq1 [$];

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std8 (
        .clk(clk), .clr(clr), .wr_en(wrEn), .data_in_fifo(dataIn), .rd_en(rdEn),
        .data_out_fifo(dout[0]), .valid_out(vldO[0]), .full(fullO[0]), .empty(emptyO[0]),
        .almost_full(afO[0]), .almost_empty(aeO[0]), .count(cntO[0]),
        .overflow(ovfO[0]), .underflow(udfO[0])
    );

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(6), .ADDR_WIDTH(3), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_wrap6 (
        .clk(clk), .clr(clr), .wr_en(wrEn), .data_in_fifo(dataIn), .rd_en(rdEn),
        .data_out_fifo(dout[1]), .valid_out(vldO[1]), .full(fullO[1]), .empty(emptyO[1]),
        .almost_full(afO[1]), .almost_empty(aeO[1]), .count(cntO[1]),
        .overflow(ovfO[1]), .underflow(udfO[1])
    );

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft8 (
        .clk(clk), .clr(clr), .wr_en(wrEn), .data_in_fifo(dataIn), .rd_en(rdEn),
        .data_out_fifo(dout[2]), .valid_out(vldO[2]), .full(fullO[2]), .empty(emptyO[2]),
        .almost_full(afO[2]), .almost_empty(aeO[2]), .count(cntO[2]),
        .overflow(ovfO[2]), .underflow(udfO[2])
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s dut%0d actual=%h required=%h", name, k, act, req);
        end
    endtask

    // Drive one cycle of inputs and predict every instance's state after the next edge.
    task automatic applyStimulus(input bit w, input bit r, input bit c, input logic [15:0] d);
        cyc_t e;
        @(negedge clk);
        wrEn   = w;
        rdEn   = r;
        clr    = c;
        dataIn = d;
        for (int k = 0; k < 3; k++) begin
            bit          racc;
            bit          wacc;
            bit          rdval;
            int          tail;
            logic [15:0] rv;
            racc  = 1'b0;
            wacc  = 1'b0;
            rdval = 1'b0;
            if (c) begin
                mcnt[k]  = 0;
                mhead[k] = 0;
                mlast[k] = '0;
                e[k].ovf = 1'b0;
                e[k].udf = 1'b0;
            end else begin
                racc = r && (mcnt[k] > 0);
                wacc = w && ((mcnt[k] < dep[k]) || racc);
                tail = (mhead[k] + mcnt[k]) % dep[k];
                if (racc) begin
                    rv       = mmem[k][mhead[k]];
                    mhead[k] = (mhead[k] + 1) % dep[k];
                    if (!fw[k]) begin
                        mlast[k] = rv;
                        rdval    = 1'b1;
                        if (k == 0) rdq0.push_back(rv);
                        else        rdq1.push_back(rv);
                    end
                end
                if (wacc) mmem[k][tail] = d;
                mcnt[k] = mcnt[k] + int'(wacc) - int'(racc);
                e[k].ovf = w && !wacc;
                e[k].udf = r && !racc;
            end
            e[k].cnt   = 4'(mcnt[k]);
            e[k].full  = (mcnt[k] == dep[k]);
            e[k].empty = (mcnt[k] == 0);
            e[k].af    = (mcnt[k] >= afl[k]);
            e[k].ae    = (mcnt[k] <= ael[k]);
            e[k].vld   = fw[k] ? (mcnt[k] > 0) : rdval;
            e[k].dchk  = fw[k] ? (mcnt[k] > 0) : 1'b1;
            e[k].data  = fw[k] ? mmem[k][mhead[k]] : mlast[k];
        end
        expq.push_back(e);
    endtask

    // Monitor: after each edge, pop the predicted state and compare; pop read data on valid.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                cyc_t e;
                e = expq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checkOutput("count",        k, 32'(cntO[k]),   32'(e[k].cnt));
                    checkOutput("full",         k, 32'(fullO[k]),  32'(e[k].full));
                    checkOutput("empty",        k, 32'(emptyO[k]), 32'(e[k].empty));
                    checkOutput("almost_full",  k, 32'(afO[k]),    32'(e[k].af));
                    checkOutput("almost_empty", k, 32'(aeO[k]),    32'(e[k].ae));
                    checkOutput("overflow",     k, 32'(ovfO[k]),   32'(e[k].ovf));
                    checkOutput("underflow",    k, 32'(udfO[k]),   32'(e[k].udf));
                    checkOutput("valid_out",    k, 32'(vldO[k]),   32'(e[k].vld));
                    if (e[k].dchk) checkOutput("data_out", k, 32'(dout[k]), 32'(e[k].data));
                end
                checkOutput("wrap_wr_ptr_lt6", 1, 32'(u_wrap6.wr_ptr < 3'd6), 32'd1);
                checkOutput("wrap_rd_ptr_lt6", 1, 32'(u_wrap6.rd_ptr < 3'd6), 32'd1);
            end
            if (vldO[0] === 1'b1) begin
                if (rdq0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rd_seq dut0 actual=%h required=none", dout[0]);
                end else begin
                    checkOutput("rd_seq", 0, 32'(dout[0]), 32'(rdq0.pop_front()));
                end
            end
            if (vldO[1] === 1'b1) begin
                if (rdq1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rd_seq dut1 actual=%h required=none", dout[1]);
                end else begin
                    checkOutput("rd_seq", 1, 32'(dout[1]), 32'(rdq1.pop_front()));
                end
            end
        end
    end

    // Directed phases followed by randomized traffic.
    initial begin
        clr    = 1'b1;
        wrEn   = 1'b0;
        rdEn   = 1'b0;
        dataIn = '0;
        for (int k = 0; k < 3; k++) begin
            mhead[k] = 0;
            mcnt[k]  = 0;
            mlast[k] = '0;
            for (int i = 0; i < 8; i++) mmem[k][i] = '0;
        end

        $display("[TB] reset");
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);

        $display("[TB] fill 1..8, overflow, read+write at full");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(i));
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h00EE);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0009);

        $display("[TB] drain, underflow, read+write at empty");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0033);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);

        $display("[TB] fall-through single word");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h00AA);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);

        $display("[TB] interleaved wrap-around");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, (i % 3) != 0, 1'b0, 16'(16'h0100 + i));
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 63) == 0), 16'($urandom));
        end
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);

        @(posedge clk);
        #2;
        checkOutput("expq_drained", 0, 32'(expq.size()), 32'd0);
        checkOutput("rdq_drained",  0, 32'(rdq0.size()), 32'd0);
        checkOutput("rdq_drained",  1, 32'(rdq1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
